unpack: RTL and testbench

UNPACK -- requirements
Module: unpack

---
 rtl/unpack_pkg.sv | 10 +
 rtl/unpack_wbuf.sv | 41 ++++
 rtl/unpack.sv | 71 +++++++
 tb/tb_unpack.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/unpack_pkg.sv
// unpack_pkg: shared lane-index/occupancy types and popcount helper for the pack/unpack blocks.
package unpack_pkg;
  localparam int MAX_N = 64;
  typedef logic [$clog2(MAX_N):0] idx_t;
  typedef logic [$clog2(MAX_N)+1:0] occ_t;
  function automatic idx_t popcnt(input logic [MAX_N-1:0] v);
    popcnt = '0;
    for (int i = 0; i < MAX_N; i++) popcnt += idx_t'(v[i]);
  endfunction
endpackage

// File: rtl/unpack_wbuf.sv
// unpack_wbuf: 2N-entry in-order circular word buffer with N-wide push and pop.
module unpack_wbuf
  import unpack_pkg::*;
#(
  parameter int N = 8,
  parameter int W = 32,
  localparam int CW = $clog2(N) + 1,
  localparam int OW = $clog2(N) + 2,
  localparam int D = 2 * N,
  localparam int PW = $clog2(D)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CW-1:0]       push_cnt,
  input  logic [N-1:0][W-1:0] push_w,
  input  logic [CW-1:0]       pop_cnt,
  output logic [N-1:0][W-1:0] pop_w,
  output logic [OW-1:0]       occ
);
  logic [W-1:0] mem [D];
  logic [PW-1:0] rd, wr;
  function automatic logic [PW-1:0] wrap(input logic [PW-1:0] p, input int o);
    wrap = PW'((int'(p) + o) % D);
  endfunction
  always_ff @(posedge clk)
    for (int i = 0; i < N; i++)
      if (i < int'(push_cnt)) mem[wrap(wr, i)] <= push_w[i];
  // Reads come from registered storage only, so a word is never poppable in its push cycle.
  always_comb
    for (int i = 0; i < N; i++) pop_w[i] = mem[wrap(rd, i)];
  always_ff @(posedge clk)
    if (!rst_n) begin
      rd <= '0;
      wr <= '0;
      occ <= '0;
    end else begin
      wr <= wrap(wr, int'(push_cnt));
      rd <= wrap(rd, int'(pop_cnt));
      occ <= occ + OW'(push_cnt) - OW'(pop_cnt);
    end
endmodule

// File: rtl/unpack.sv
// unpack: scatters buffered words into the lanes selected by a mask.
// Define UNPACK_ZERO_FILL_EN to zero unselected lanes on each beat instead of holding them.
module unpack
  import unpack_pkg::*;
#(
  parameter int N = 8,
  parameter int W = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_vld,
  input  logic [$clog2(N):0]         in_cnt,
  input  logic [N-1:0][W-1:0]        in_w,
  output logic                       in_rdy,
  input  logic                       msk_vld,
  input  logic [N-1:0]               msk,
  output logic                       msk_rdy,
  output logic                       out_vld_r,
  output logic [N-1:0][W-1:0]        out_r,
  output logic [N-1:0]               out_msk_r,
  input  logic                       out_rdy
);
  localparam int CW = $clog2(N) + 1;
  localparam int OW = $clog2(N) + 2;
  localparam int KW = $clog2(N) > 0 ? $clog2(N) : 1;
`ifdef UNPACK_ZERO_FILL_EN
  localparam logic ZF = 1'b1;
`else
  localparam logic ZF = 1'b0;
`endif
  logic [OW-1:0] occ;
  logic [N-1:0][W-1:0] pop_w, nxt;
  logic [CW-1:0] pc, push_cnt, pop_cnt;
  logic [KW-1:0] k;
  logic fire, acc;
  assign pc = CW'(popcnt(MAX_N'(msk)));
  assign in_rdy = occ_t'(occ) <= occ_t'(N);
  assign msk_rdy = (occ_t'(occ) >= occ_t'(pc)) & (~out_vld_r | out_rdy);
  assign fire = msk_vld & msk_rdy;
  assign acc = in_vld & in_rdy;
  assign push_cnt = acc ? in_cnt : '0;
  assign pop_cnt = fire ? pc : '0;
  unpack_wbuf #(.N(N), .W(W)) u_buf (
    .clk(clk),
    .rst_n(rst_n),
    .push_cnt(push_cnt),
    .push_w(in_w),
    .pop_cnt(pop_cnt),
    .pop_w(pop_w),
    .occ(occ)
  );
  // k-th popped word lands in the lane of the k-th set mask bit, LSB first.
  always_comb begin
    k = '0;
    for (int i = 0; i < N; i++) begin
      nxt[i] = msk[i] ? pop_w[k] : (ZF ? '0 : out_r[i]);
      k += KW'(msk[i]);
    end
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      out_vld_r <= 1'b0;
      out_msk_r <= '0;
    end else if (fire) begin
      out_vld_r <= 1'b1;
      out_msk_r <= msk;
      out_r <= nxt;
    end else if (out_rdy) out_vld_r <= 1'b0;
  always_ff @(posedge clk)
    if (rst_n && acc) assert (int'(in_cnt) <= N);
endmodule

// File: tb/tb_unpack.sv
// tb_unpack: directed stimulus with a scoreboard of expected output beats.
module tb_unpack;
  localparam int N = 8;
  localparam int W = 32;
`ifdef UNPACK_ZERO_FILL_EN
  localparam bit ZF = 1'b1;
`else
  localparam bit ZF = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0, in_vld = 1'b0, msk_vld = 1'b0, out_rdy = 1'b1;
  logic [3:0] in_cnt = '0;
  logic [N-1:0][W-1:0] in_w = '0;
  logic [N-1:0] msk = '0;
  logic in_rdy, msk_rdy, out_vld_r;
  logic [N-1:0][W-1:0] out_r;
  logic [N-1:0] out_msk_r;
  int n_chk = 0, n_pass = 0;
  typedef struct {
    logic [N-1:0][W-1:0] d;
    logic [N-1:0] msk;
    logic [N-1:0] ok;
  } beat_t;
  beat_t sb[$];
  beat_t mb, cb;
  logic [W-1:0] fq[$];
  logic [N-1:0][W-1:0] last;
  logic [N-1:0] known = '0;
  always #5 clk = ~clk;
  unpack #(.N(N), .W(W)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_vld(in_vld),
    .in_cnt(in_cnt),
    .in_w(in_w),
    .in_rdy(in_rdy),
    .msk_vld(msk_vld),
    .msk(msk),
    .msk_rdy(msk_rdy),
    .out_vld_r(out_vld_r),
    .out_r(out_r),
    .out_msk_r(out_msk_r),
    .out_rdy(out_rdy)
  );
  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
  endtask
  // Monitor compares any consumed beat, then the model records this cycle's handshakes.
  always @(negedge clk)
    if (!rst_n) begin
      fq.delete();
      sb.delete();
    end else begin
      if (out_vld_r && out_rdy) begin
        chk("beat_pending", 64'(sb.size() > 0), 64'd1);
        if (sb.size() > 0) begin
          cb = sb.pop_front();
          chk("beat_msk", 64'(out_msk_r), 64'(cb.msk));
          for (int i = 0; i < N; i++)
            if (cb.ok[i]) chk($sformatf("beat_lane%0d", i), 64'(out_r[i]), 64'(cb.d[i]));
        end
      end
      if (msk_vld && msk_rdy) begin
        for (int i = 0; i < N; i++)
          if (msk[i]) begin
            last[i] = fq.size() > 0 ? fq.pop_front() : 'x;
            known[i] = 1'b1;
          end else if (ZF) begin
            last[i] = '0;
            known[i] = 1'b1;
          end
        mb.d = last;
        mb.msk = msk;
        mb.ok = known;
        sb.push_back(mb);
      end
      if (in_vld && in_rdy)
        for (int i = 0; i < int'(in_cnt); i++) fq.push_back(in_w[i]);
    end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic iv, input int cnt, input logic mv, input logic [N-1:0] m, input int tag);
    in_vld = iv;
    in_cnt = 4'(cnt);
    msk_vld = mv;
    msk = m;
    for (int i = 0; i < N; i++) in_w[i] = W'((tag << 8) | i);
  endtask
  int tbl_iv[10] = '{1, 1, 1, 1, 1, 1, 1, 1, 0, 0};
  int tbl_mv[10] = '{0, 0, 0, 0, 1, 0, 1, 0, 1, 1};
  int tbl_rdy[10] = '{1, 1, 0, 0, 0, 1, 0, 1, 0, 1};
  int tbl_occ[10] = '{0, 8, 16, 16, 16, 8, 16, 8, 16, 8};
  initial begin
    repeat (3) step();
    rst_n = 1'b1;
    drive(0, 0, 0, 8'h01, 0);
    @(negedge clk);
    chk("rst_out_vld", 64'(out_vld_r), 0);
    chk("rst_out_msk", 64'(out_msk_r), 0);
    chk("rst_occ", 64'(dut.u_buf.occ), 0);
    chk("rst_in_rdy", 64'(in_rdy), 1);
    chk("rst_msk_rdy", 64'(msk_rdy), 0);
    // three words scattered to lanes 2,5,7
    step(); drive(1, 3, 0, 0, 1);
    @(negedge clk); chk("abc_in_rdy", 64'(in_rdy), 1);
    step(); drive(0, 0, 1, 8'hA4, 0);
    @(negedge clk); chk("abc_msk_rdy", 64'(msk_rdy), 1);
    step(); drive(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("abc_vld", 64'(out_vld_r), 1);
    chk("abc_msk", 64'(out_msk_r), 64'hA4);
    chk("abc_lane2", 64'(out_r[2]), 64'h100);
    chk("abc_lane5", 64'(out_r[5]), 64'h101);
    chk("abc_lane7", 64'(out_r[7]), 64'h102);
    chk("abc_occ", 64'(dut.u_buf.occ), 0);
    // mask needs 4 words while only 2 are buffered
    step(); drive(1, 2, 0, 0, 2);
    @(negedge clk); chk("short_push", 64'(in_rdy), 1);
    step(); drive(1, 2, 1, 8'h0F, 3);
    @(negedge clk);
    chk("short_msk_rdy", 64'(msk_rdy), 0);
    chk("short_occ", 64'(dut.u_buf.occ), 2);
    step(); drive(0, 0, 1, 8'h0F, 0);
    @(negedge clk);
    chk("short_fire", 64'(msk_rdy), 1);
    chk("short_occ4", 64'(dut.u_buf.occ), 4);
    step(); drive(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("short_msk", 64'(out_msk_r), 64'h0F);
    chk("short_l0", 64'(out_r[0]), 64'h200);
    chk("short_l1", 64'(out_r[1]), 64'h201);
    chk("short_l2", 64'(out_r[2]), 64'h300);
    chk("short_l3", 64'(out_r[3]), 64'h301);
    // full-beat pushes against the occ<=N admission rule
    for (int c = 0; c < 10; c++) begin
      step(); drive(tbl_iv[c][0], 8, tbl_mv[c][0], 8'hFF, 16 + c);
      @(negedge clk);
      chk($sformatf("full_in_rdy%0d", c), 64'(in_rdy), 64'(tbl_rdy[c]));
      chk($sformatf("full_occ%0d", c), 64'(dut.u_buf.occ), 64'(tbl_occ[c]));
    end
    step(); drive(0, 0, 0, 0, 0);
    @(negedge clk); chk("full_drained", 64'(dut.u_buf.occ), 0);
    // backpressure holds the beat and blocks the next mask
    step(); drive(1, 8, 0, 0, 8'h40);
    @(negedge clk); chk("bp_push", 64'(in_rdy), 1);
    step(); out_rdy = 1'b0; drive(0, 0, 1, 8'h03, 0);
    @(negedge clk); chk("bp_first_fire", 64'(msk_rdy), 1);
    step(); drive(0, 0, 1, 8'h0C, 0);
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      chk($sformatf("bp_msk_rdy%0d", j), 64'(msk_rdy), 0);
      chk($sformatf("bp_occ%0d", j), 64'(dut.u_buf.occ), 6);
      chk($sformatf("bp_vld%0d", j), 64'(out_vld_r), 1);
      chk($sformatf("bp_l0_%0d", j), 64'(out_r[0]), 64'h4000);
      chk($sformatf("bp_l1_%0d", j), 64'(out_r[1]), 64'h4001);
      step();
    end
    out_rdy = 1'b1;
    @(negedge clk); chk("bp_release", 64'(msk_rdy), 1);
    step(); drive(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("bp_next_msk", 64'(out_msk_r), 64'h0C);
    chk("bp_next_l2", 64'(out_r[2]), 64'h4002);
    chk("bp_next_occ", 64'(dut.u_buf.occ), 4);
    // empty mask still produces a beat
    step(); drive(0, 0, 1, 8'h00, 0);
    @(negedge clk); chk("z_msk_rdy", 64'(msk_rdy), 1);
    step(); drive(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("z_vld", 64'(out_vld_r), 1);
    chk("z_msk", 64'(out_msk_r), 0);
    chk("z_occ", 64'(dut.u_buf.occ), 4);
    chk("z_l0", 64'(out_r[0]), ZF ? 64'h0 : 64'h4000);
    chk("z_l2", 64'(out_r[2]), ZF ? 64'h0 : 64'h4002);
    // reset with words buffered and a beat stalled
    step(); drive(1, 4, 0, 0, 8'h50);
    @(negedge clk); chk("r_push", 64'(in_rdy), 1);
    step(); out_rdy = 1'b0; drive(0, 0, 1, 8'h03, 0);
    @(negedge clk); chk("r_fire", 64'(msk_rdy), 1);
    step(); drive(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("r_pre_occ", 64'(dut.u_buf.occ), 6);
    chk("r_pre_vld", 64'(out_vld_r), 1);
    step(); rst_n = 1'b0;
    step(); rst_n = 1'b1; out_rdy = 1'b1; drive(0, 0, 0, 8'h01, 0);
    @(negedge clk);
    chk("r_occ", 64'(dut.u_buf.occ), 0);
    chk("r_vld", 64'(out_vld_r), 0);
    chk("r_rd", 64'(dut.u_buf.rd), 0);
    chk("r_wr", 64'(dut.u_buf.wr), 0);
    chk("r_in_rdy", 64'(in_rdy), 1);
    chk("r_msk_rdy", 64'(msk_rdy), 0);
    step(); drive(1, 1, 0, 0, 8'h60);
    step(); drive(0, 0, 1, 8'h01, 0);
    step(); drive(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("r_new_l0", 64'(out_r[0]), 64'h6000);
    chk("r_new_msk", 64'(out_msk_r), 64'h01);
    repeat (2) step();
    chk("sb_empty", 64'(sb.size()), 0);
    chk("fifo_empty", 64'(fq.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
